// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_unit : load/store unit between a core and a word-wide memory.    |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_exc
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_MIS  = 2'b01;
  localparam logic [1:0] EXC_TMO  = 2'b10;
  localparam logic [1:0] EXC_ILL  = 2'b11;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // Low three type bits select the operation; bit 3 only gates legality.
  function automatic logic [1:0] f_size(input logic [2:0] k);
    case (k)
      3'b000, 3'b011, 3'b100: f_size = SZ_B;
      3'b001, 3'b101, 3'b111: f_size = SZ_H;
      default:                f_size = SZ_W;
    endcase
  endfunction

  function automatic logic f_store(input logic [2:0] k);
    f_store = k[2] & ~(k[1] & k[0]);
  endfunction

  function automatic logic f_signed(input logic [2:0] k);
    f_signed = (k == 3'b000) || (k == 3'b001);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  exc_q, exc_d;
  logic [2:0]  kind_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        req_misaligned;
  logic [1:0]  req_size;
  logic [1:0]  cur_size;
  logic        cur_store;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [3:0]  store_mask;

  assign accept    = (state_q == S_IDLE) && req_valid;
  assign req_size  = f_size(req_type[2:0]);
  assign cur_size  = f_size(kind_q);
  assign cur_store = f_store(kind_q);

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      SZ_H:    req_misaligned = req_addr[0];
      SZ_W:    req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
  end

  assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = lane;
    case (cur_size)
      SZ_B:    load_ext = {{24{f_signed(kind_q) & lane[7]}}, lane[7:0]};
      SZ_H:    load_ext = {{16{f_signed(kind_q) & lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    store_mask = 4'b1111;
    case (cur_size)
      SZ_B:    store_mask = 4'b0001 << addr_q[1:0];
      SZ_H:    store_mask = 4'b0011 << addr_q[1:0];
      default: store_mask = 4'b1111;
    endcase
  end

  // State register and the response/counter registers it steers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      data_q  <= 32'd0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q  <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      kind_q  <= req_type[2:0];
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d  = 8'd0;
          data_d = 32'd0;
          if (!req_type[3]) begin
            state_d = S_RESP;
            exc_d   = EXC_ILL;
          end else if (req_misaligned) begin
            state_d = S_RESP;
            exc_d   = EXC_MIS;
          end else begin
            state_d = S_ACCESS;
            exc_d   = EXC_NONE;
          end
        end
      end
      S_ACCESS: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (mem_ack) begin
          state_d = S_RESP;
          exc_d   = EXC_NONE;
          data_d  = cur_store ? 32'd0 : load_ext;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_RESP;
          exc_d   = EXC_TMO;
          data_d  = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_mask   = 4'b1111;
    case (state_q)
      S_IDLE:   req_ready = 1'b1;
      S_ACCESS: begin
        mem_read  = ~cur_store;
        mem_write = cur_store;
        mem_mask  = cur_store ? store_mask : 4'b1111;
      end
      S_RESP:   resp_valid = 1'b1;
      default:  req_ready = 1'b0;
    endcase
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign resp_data = data_q;
  assign resp_exc  = exc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit : self-checking bench for mem_access_unit (TIMEOUT=4).   |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_type = 4'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [1:0]  resp_exc;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_exc(resp_exc)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    int          rdy_dly;
    logic [1:0]  exc;
    logic [31:0] data;
    int          lat;
    int          strobes;
    logic [3:0]  mask;
    logic [31:0] mwdata;
  } vec_t;

  // Reference: derived from access width/sign rules with plain arithmetic.
  function automatic void model(input logic [3:0] t, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int ack_dly,
                                output logic [1:0] exc, output logic [31:0] data, output int lat,
                                output int strobes, output logic [3:0] mask, output logic [31:0] mwd);
    int     bytes;
    bit     store;
    bit     sgn;
    int     off;
    longint lane;
    longint span;
    bytes = 4; store = 0; sgn = 0;
    off = int'(a[1:0]);
    case (t[2:0])
      3'd0: begin bytes = 1; sgn = 1; end
      3'd1: begin bytes = 2; sgn = 1; end
      3'd2: bytes = 4;
      3'd3: bytes = 1;
      3'd4: begin bytes = 1; store = 1; end
      3'd5: begin bytes = 2; store = 1; end
      3'd6: begin bytes = 4; store = 1; end
      default: bytes = 2;
    endcase
    mask = store ? 4'(((1 << bytes) - 1) << off) : 4'hF;
    mwd  = wd << (8 * off);
    data = 32'd0;
    if (!t[3]) begin
      exc = 2'b11; lat = 1; strobes = 0;
    end else if ((off % bytes) != 0) begin
      exc = 2'b01; lat = 1; strobes = 0;
    end else if (ack_dly >= 0 && ack_dly < TMO) begin
      exc = 2'b00; lat = ack_dly + 2; strobes = ack_dly + 1;
      if (!store) begin
        span = longint'(1) << (8 * bytes);
        lane = (longint'(rd) >> (8 * off)) % span;
        if (sgn && lane >= span / 2) lane = lane - span;
        data = 32'(lane);
      end
    end else begin
      exc = 2'b10; lat = TMO + 1; strobes = TMO;
    end
  endfunction

  task automatic run_txn(input string tag, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_dly,
                         input int rdy_dly, input logic [1:0] e_exc, input logic [31:0] e_data,
                         input int e_lat, input int e_str, input logic [3:0] e_mask,
                         input logic [31:0] e_mwd);
    int n;
    int str;
    bit attr_ok;
    bit stable_ok;
    bit is_st;
    is_st = t[3] && (t[2:0] == 3'd4 || t[2:0] == 3'd5 || t[2:0] == 3'd6);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0; req_type = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0; str = 0; attr_ok = 1;
    while (!resp_valid && n < 64) begin
      if (mem_read || mem_write) begin
        if (mem_addr !== {a[31:2], 2'b00} || mem_mask !== e_mask ||
            mem_write !== is_st || mem_read !== !is_st ||
            (is_st && mem_wdata !== e_mwd) || req_ready !== 1'b0)
          attr_ok = 0;
        mem_ack = (str == ack_dly);
        mem_rdata = mem_ack ? rd : $urandom;
        str++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    mem_ack = 1'b0;
    check({tag, " latency"}, 32'(n + 1), 32'(e_lat));
    check({tag, " strobe_cycles"}, 32'(str), 32'(e_str));
    check({tag, " strobe_attrs"}, 32'(attr_ok), 32'd1);
    stable_ok = 1;
    for (int i = 0; i < rdy_dly; i++) begin
      if (resp_valid !== 1'b1 || resp_data !== e_data || resp_exc !== e_exc ||
          mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b0)
        stable_ok = 0;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    check({tag, " resp_stable"}, 32'(stable_ok), 32'd1);
    check({tag, " resp_exc"}, 32'(resp_exc), 32'(e_exc));
    check({tag, " resp_data"}, resp_data, e_data);
    // A request offered during the release cycle must not be taken.
    resp_ready = 1'b1; req_valid = 1'b1; req_type = 4'b1010; req_addr = 32'h0;
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check({tag, " release"}, 32'({req_ready, resp_valid, mem_read, mem_write}), 32'b1000);
  endtask

  vec_t vecs[15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  m_exc;
    logic [31:0] m_data;
    int          m_lat;
    int          m_str;
    logic [3:0]  m_mask;
    logic [31:0] m_mwd;
    bit          quiet;

    vecs[0]  = '{4'b1000, 32'h103, 32'h0, 32'h80FF1234, 0, 1, 2'b00, 32'hFFFFFF80, 2, 1, 4'hF, 32'h0};
    vecs[1]  = '{4'b1101, 32'h202, 32'h0000ABCD, 32'h0, 2, 0, 2'b00, 32'h0, 4, 3, 4'b1100, 32'hABCD0000};
    vecs[2]  = '{4'b1010, 32'h301, 32'h0, 32'h0, 0, 0, 2'b01, 32'h0, 1, 0, 4'hF, 32'h0};
    vecs[3]  = '{4'b0110, 32'h0, 32'h0, 32'h0, 0, 0, 2'b11, 32'h0, 1, 0, 4'hF, 32'h0};
    vecs[4]  = '{4'b1111, 32'h10, 32'h0, 32'hFFFFFFFF, -1, 5, 2'b10, 32'h0, 5, 4, 4'hF, 32'h0};
    vecs[5]  = '{4'b1001, 32'h2, 32'h0, 32'h80010000, 0, 0, 2'b00, 32'hFFFF8001, 2, 1, 4'hF, 32'h0};
    vecs[6]  = '{4'b1011, 32'h1, 32'h0, 32'h0000F000, 0, 0, 2'b00, 32'h000000F0, 2, 1, 4'hF, 32'h0};
    vecs[7]  = '{4'b1010, 32'h4, 32'h0, 32'hDEADBEEF, 1, 2, 2'b00, 32'hDEADBEEF, 3, 2, 4'hF, 32'h0};
    vecs[8]  = '{4'b1100, 32'h3, 32'h5A, 32'h0, 0, 0, 2'b00, 32'h0, 2, 1, 4'b1000, 32'h5A000000};
    vecs[9]  = '{4'b1110, 32'h8, 32'h12345678, 32'hFFFFFFFF, 3, 0, 2'b00, 32'h0, 5, 4, 4'hF, 32'h12345678};
    vecs[10] = '{4'b1001, 32'h1, 32'h0, 32'h0, 0, 0, 2'b01, 32'h0, 1, 0, 4'hF, 32'h0};
    vecs[11] = '{4'b1101, 32'h3, 32'h0, 32'h0, 0, 0, 2'b01, 32'h0, 1, 0, 4'hF, 32'h0};
    vecs[12] = '{4'b1111, 32'h6, 32'h0, 32'h80010000, 0, 0, 2'b00, 32'h00008001, 2, 1, 4'hF, 32'h0};
    vecs[13] = '{4'b1000, 32'h0, 32'h0, 32'h1234567F, 0, 0, 2'b00, 32'h0000007F, 2, 1, 4'hF, 32'h0};
    vecs[14] = '{4'b1100, 32'h1, 32'hFFFFFF5A, 32'h0, 0, 0, 2'b00, 32'h0, 2, 1, 4'b0010, 32'hFFFF5A00};

    #12;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst mem_mask", 32'(mem_mask), 32'hF);
    check("rst strobes_resp", 32'({mem_read, mem_write, resp_valid, resp_exc}), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].typ, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
              vecs[i].ack_dly, vecs[i].rdy_dly, vecs[i].exc, vecs[i].data, vecs[i].lat,
              vecs[i].strobes, vecs[i].mask, vecs[i].mwdata);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  t;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      int          ad;
      t  = 4'($urandom_range(0, 15));
      a  = $urandom;
      wd = $urandom;
      rd = $urandom;
      ad = int'($urandom_range(0, 6)) - 1;
      model(t, a, wd, rd, ad, m_exc, m_data, m_lat, m_str, m_mask, m_mwd);
      run_txn($sformatf("rnd%0d", i), t, a, wd, rd, ad, int'($urandom_range(0, 3)),
              m_exc, m_data, m_lat, m_str, m_mask, m_mwd);
    end

    // Reset in the middle of a load that is still waiting for its ack.
    req_valid = 1'b1; req_type = 4'b1010; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_access strobe_before", 32'(mem_read), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_access outs", 32'({req_ready, mem_read, mem_write, resp_valid}), 32'b1000);
    #3 rst_n = 1'b1;
    quiet = 1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || mem_read !== 1'b0 || req_ready !== 1'b1) quiet = 0;
    end
    mem_ack = 1'b0;
    check("abort_access no_resp", 32'(quiet), 32'd1);

    // Reset while a response is pending.
    req_valid = 1'b1; req_type = 4'b0001; req_addr = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_resp valid_before", 32'(resp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_resp outs", 32'({req_ready, resp_valid, resp_exc}), 32'b1000);
    #3 rst_n = 1'b1;
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 0;
    end
    check("abort_resp no_resp", 32'(quiet), 32'd1);

    run_txn("post_reset", 4'b1010, 32'h44, 32'h0, 32'h01020304, 0, 1,
            2'b00, 32'h01020304, 2, 1, 4'hF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
